// File: rtl/beta_pkg.sv
// Shared types and default sizing for the beta memory arbiter.
package beta_pkg;
  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, RESP} state_e;

  localparam int TIMEOUT_DEF     = 64;
  localparam int MAX_DSTREAK_DEF = 4;
endpackage

// File: rtl/beta_mem_arbiter_if.sv
// Requester and memory-side signal bundle around the arbiter.
interface beta_mem_arbiter_if;
  logic        iReq;
  logic [31:0] iAddress;
  logic [31:0] iData;
  logic        iReady;
  logic        iFault;
  logic        dReq;
  logic        dWrite;
  logic [31:0] dAddress;
  logic [31:0] dWdata;
  logic [31:0] dRdata;
  logic        dReady;
  logic        dFault;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic        memRe;
  logic        memWe;
  logic [31:0] memRdata;
  logic        memAck;
  logic        memFault;

  modport arb (
    input  iReq, iAddress, dReq, dWrite, dAddress, dWdata, memRdata, memAck, memFault,
    output iData, iReady, iFault, dRdata, dReady, dFault, memAddr, memWdata, memRe, memWe
  );

  modport env (
    output iReq, iAddress, dReq, dWrite, dAddress, dWdata, memRdata, memAck, memFault,
    input  iData, iReady, iFault, dRdata, dReady, dFault, memAddr, memWdata, memRe, memWe
  );
endinterface

// File: rtl/beta_timeout_counter.sv
// Counts busy cycles without an ack; expired flags the last allowed cycle.
module beta_timeout_counter
  import beta_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == W'(TIMEOUT - 1));

  // Hold at the terminal value so the count never wraps back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                 cnt_d = '0;
    else if (en && !expired) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/beta_mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory port, with data-streak
// fairness and a no-ack timeout that forces a fault response.
module beta_mem_arbiter
  import beta_pkg::*;
#(
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int MAX_DSTREAK = MAX_DSTREAK_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iReq,
  input  logic [31:0] iAddress,
  output logic [31:0] iData,
  output logic        iReady,
  output logic        iFault,
  input  logic        dReq,
  input  logic        dWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWdata,
  output logic [31:0] dRdata,
  output logic        dReady,
  output logic        dFault,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic        memRe,
  output logic        memWe,
  input  logic [31:0] memRdata,
  input  logic        memAck,
  input  logic        memFault
);
  localparam int SW = (MAX_DSTREAK > 0) ? $clog2(MAX_DSTREAK + 1) : 1;

  state_e        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0]   idata_q, idata_d, drdata_q, drdata_d;
  logic          dwrite_q, dwrite_d;
  logic          iready_q, iready_d, dready_q, dready_d;
  logic          ifault_q, ifault_d, dfault_q, dfault_d;
  logic          tmo_clr, tmo_en, tmo_expired;
  logic          streak_full, i_wins;

  assign streak_full = (streak_q == SW'(MAX_DSTREAK));
  assign i_wins      = iReq && (!dReq || streak_full);

  beta_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dwrite_d = dwrite_q;
    idata_d  = idata_q;
    drdata_d = drdata_q;
    iready_d = 1'b0;
    dready_d = 1'b0;
    ifault_d = 1'b0;
    dfault_d = 1'b0;
    tmo_clr  = 1'b0;
    tmo_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_wins) begin
          state_d  = IBUSY;
          addr_d   = iAddress;
          dwrite_d = 1'b0;
          streak_d = '0;
          tmo_clr  = 1'b1;
        end else if (dReq) begin
          state_d  = DBUSY;
          addr_d   = dAddress;
          wdata_d  = dWdata;
          dwrite_d = dWrite;
          tmo_clr  = 1'b1;
          if (iReq && !streak_full) streak_d = streak_q + 1'b1;
        end
      end
      IBUSY, DBUSY: begin
        // An ack in the expiry cycle still wins: it is a real completion.
        if (memAck || tmo_expired) begin
          state_d = RESP;
          if (state_q == IBUSY) begin
            iready_d = 1'b1;
            ifault_d = memAck ? memFault : 1'b1;
            idata_d  = memAck ? memRdata : 32'h0;
          end else begin
            dready_d = 1'b1;
            dfault_d = memAck ? memFault : 1'b1;
            drdata_d = memAck ? memRdata : 32'h0;
          end
        end else begin
          tmo_en = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      dwrite_q <= 1'b0;
      idata_q  <= '0;
      drdata_q <= '0;
      iready_q <= 1'b0;
      dready_q <= 1'b0;
      ifault_q <= 1'b0;
      dfault_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      dwrite_q <= dwrite_d;
      idata_q  <= idata_d;
      drdata_q <= drdata_d;
      iready_q <= iready_d;
      dready_q <= dready_d;
      ifault_q <= ifault_d;
      dfault_q <= dfault_d;
    end
  end

  always_comb begin
    memRe = 1'b0;
    memWe = 1'b0;
    if (state_q == IBUSY) begin
      memRe = 1'b1;
    end else if (state_q == DBUSY) begin
      memWe = dwrite_q;
      memRe = !dwrite_q;
    end
  end

  assign memAddr  = addr_q;
  assign memWdata = wdata_q;
  assign iData    = idata_q;
  assign dRdata   = drdata_q;
  assign iReady   = iready_q;
  assign dReady   = dready_q;
  assign iFault   = ifault_q;
  assign dFault   = dfault_q;
endmodule

// File: doc/beta_mem_arbiter.md
BETA_MEM_ARBITER -- requirements
Module: beta_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: cycles without memAck before a fault response is forced.
REQ-002 SHALL have parameter MAX_DSTREAK, default 4: consecutive data grants allowed while an instruction request waits.
REQ-003 SHALL have port clk, input, 1: single clock, all state on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port iReq, input, 1: instruction fetch request, held until iReady.
REQ-006 SHALL have port iAddress, input, 32: fetch address.
REQ-007 SHALL have ports iData (output, 32), iReady (output, 1) and iFault (output, 1): fetch data, one-cycle completion pulse and fault flag.
REQ-008 SHALL have ports dReq (input, 1), dWrite (input, 1), dAddress (input, 32) and dWdata (input, 32): data request, 1 = store, address and store data.
REQ-009 SHALL have ports dRdata (output, 32), dReady (output, 1) and dFault (output, 1): load data, one-cycle completion pulse and fault flag.
REQ-010 SHALL have ports memAddr (output, 32), memWdata (output, 32), memRe (output, 1) and memWe (output, 1): shared memory address, write data, read strobe and write strobe.
REQ-011 SHALL have ports memRdata (input, 32), memAck (input, 1) and memFault (input, 1): memory read data, completion and fault.

Function
REQ-012 SHALL implement FSM states IDLE, IBUSY, DBUSY and RESP.
REQ-013 In IDLE, dReq SHALL be granted over iReq, except when the data-streak counter equals MAX_DSTREAK and iReq is high, in which case iReq SHALL be granted.
REQ-014 A grant SHALL register address, write data and direction at the clock edge, entering IBUSY or DBUSY.
REQ-015 The streak counter SHALL increment on a data grant while iReq is high, SHALL clear on an instruction grant and SHALL saturate at MAX_DSTREAK.
REQ-016 In IBUSY, memRe SHALL be 1 and memWe SHALL be 0.
REQ-017 In DBUSY, memWe SHALL equal the latched dWrite and memRe SHALL equal its inverse.
REQ-018 In every other state memRe and memWe SHALL both be 0.
REQ-019 memAddr and memWdata SHALL be driven only from the latched registers, never combinationally from the requester inputs.
REQ-020 When memAck is high in a BUSY state, the arbiter SHALL register memRdata and memFault to the owner, enter RESP, and assert that owner's Ready for exactly one cycle (the RESP cycle).
REQ-021 Minimum latency SHALL be 2 cycles (request in cycle 0, grant plus ack in cycle 1, Ready in cycle 2).
REQ-022 The timeout counter SHALL clear on grant and increment each BUSY cycle without memAck.
REQ-023 When the timeout counter reaches TIMEOUT-1 without memAck, the arbiter SHALL enter RESP with Fault=1 and data 0.
REQ-024 memAck in the same cycle as the timeout SHALL take priority: it is a normal completion.
REQ-025 In RESP, requests SHALL be ignored, so a requester that drops its request on its Ready cycle is not regranted.
REQ-026 RESP SHALL always go to IDLE; there are no back-to-back grants without IDLE.
REQ-027 Fault outputs SHALL be valid only while the matching Ready is 1 and SHALL be 0 otherwise.
REQ-028 iData and dRdata SHALL hold their last value between responses.
REQ-029 The non-owner's Ready SHALL never pulse.
REQ-030 The arbiter SHALL never assert memRe and memWe together.

Reset
REQ-031 When rst is 1 at a clock edge, state SHALL become IDLE, streak and timeout counters 0, and iReady, dReady, iFault, dFault, memRe and memWe 0.
REQ-032 After reset, iData, dRdata, memAddr and memWdata SHALL be 0.
REQ-033 Reset during IBUSY, DBUSY or RESP SHALL abort the transaction: memRe/memWe drop in the cycle after the edge and no Ready pulse is issued.
REQ-034 Requests asserted during reset SHALL be arbitrated starting from the first cycle after rst is released.

Structure
REQ-035 Package beta_pkg SHALL hold the FSM state enum (IDLE, IBUSY, DBUSY, RESP) and the default TIMEOUT and MAX_DSTREAK constants.
REQ-036 The timeout counter SHALL be one sub-module, beta_timeout_counter, with clear, enable, a width derived from TIMEOUT, and an expired output.
REQ-037 Arbitration, streak and FSM logic SHALL stay in beta_mem_arbiter.

Verification
REQ-038 Instruction fetch: iReq=1, iAddress=0x100, memAck next cycle with memRdata=0xDEADBEEF -> memRe=1 with memAddr=0x100 in cycle 1, then iReady=1 with iData=0xDEADBEEF in cycle 2.
REQ-039 Simultaneous requests: iReq=1 and dReq=1 (load at 0x200) in the same cycle -> data is granted first (memAddr=0x200), then the instruction is granted after RESP and IDLE.
REQ-040 Starvation: dReq held high with repeated loads while iReq stays high -> after 4 data grants the 5th grant goes to the instruction, and the streak counter reads 0.
REQ-041 Store timeout: dWrite=1, dAddress=0x40, dWdata=0x12345678, memAck never asserted -> memWe=1 for 64 cycles, then dReady=1, dFault=1, dRdata=0.
REQ-042 Ack at timeout boundary: memAck=1 with memFault=1 exactly in the timeout cycle -> normal completion, dReady=1 with dFault=1 and dRdata taken from memRdata.
REQ-043 Reset mid-transaction: rst=1 in the second DBUSY cycle -> memRe=0 and memWe=0 on the next cycle, no dReady pulse, and a new iReq after reset is granted normally.
